// File: rtl/chs_power_driver_if.sv
// Request/status bundle between the power/mode stage, the power driver and its observers.
interface chs_power_driver_if;
  logic [3:0] chs_power;
  logic       chs_mode;
  logic       heat_pwm;
  logic       cool_pwm;
  logic [3:0] chs_level;
  logic       chs_active_mode;
  logic       chs_busy;

  modport master (
    output chs_power, chs_mode,
    input  heat_pwm, cool_pwm, chs_level, chs_active_mode, chs_busy
  );

  modport slave (
    input  chs_power, chs_mode,
    output heat_pwm, cool_pwm, chs_level, chs_active_mode, chs_busy
  );
endinterface

// File: rtl/chs_power_driver.sv
// Soft-start slot PWM driver for the heater/cooler pair.
// Mode reversals always pass through ramp-down and a dead band, so the two drives never overlap.
module chs_power_driver #(
  parameter int PRESCALE     = 4,
  parameter int RAMP_PERIODS = 2,
  parameter int DEAD_CYCLES  = 16
) (
  input  logic               clk,
  input  logic               rst,
  chs_power_driver_if.slave  bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [RW-1:0] PER_LAST   = RW'(RAMP_PERIODS - 1);
  localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2,
    DEAD = 2'd3
  } state_t;

  state_t          state_r, state_nx_s;
  logic [3:0]      power_q_r;
  logic            mode_q_r;
  logic [PW-1:0]   presc_r;
  logic [2:0]      slot_r;
  logic [RW-1:0]   per_r;
  logic [DW-1:0]   dead_r;
  logic [3:0]      level_r, level_nx_s, step_lvl_s;
  logic            active_r, active_nx_s;
  logic            heat_r, cool_r, busy_r;
  logic [3:0]      target_s;
  logic            pb_s, sb_s, differ_s, dead_done_s, pwm_raw_s;

  assign target_s    = (power_q_r > 4'd8) ? 4'd8 : power_q_r;
  assign pb_s        = (slot_r == 3'd7) && (presc_r == PRESC_LAST);
  assign sb_s        = pb_s && (per_r == PER_LAST);
  assign differ_s    = (mode_q_r != active_r);
  assign dead_done_s = (dead_r == DEAD_LAST);
  assign pwm_raw_s   = ({1'b0, slot_r} < level_r);

  // Input sampling stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      power_q_r <= 4'd0;
      mode_q_r  <= 1'b0;
    end else begin
      power_q_r <= bus.chs_power;
      mode_q_r  <= bus.chs_mode;
    end
  end

  // Free-running prescale / slot / period timebase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
      slot_r  <= 3'd0;
      per_r   <= '0;
    end else begin
      if (presc_r == PRESC_LAST) begin
        presc_r <= '0;
        slot_r  <= slot_r + 3'd1;
      end else begin
        presc_r <= presc_r + PW'(1);
      end
      if (pb_s) begin
        per_r <= (per_r == PER_LAST) ? '0 : per_r + RW'(1);
      end
    end
  end

  // Next-state, level and applied-mode decisions
  always_comb begin
    state_nx_s  = state_r;
    level_nx_s  = level_r;
    active_nx_s = active_r;
    if (level_r < target_s) begin
      step_lvl_s = level_r + 4'd1;
    end else if (level_r > target_s) begin
      step_lvl_s = level_r - 4'd1;
    end else begin
      step_lvl_s = level_r;
    end
    case (state_r)
      IDLE: begin
        if (target_s != 4'd0) begin
          state_nx_s = differ_s ? DEAD : RAMP;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RAMP: begin
        // A pending reversal drains the level before anything else is considered
        if (differ_s) begin
          if (level_r == 4'd0) begin
            state_nx_s = DEAD;
          end else if (sb_s) begin
            level_nx_s = level_r - 4'd1;
            state_nx_s = (level_r == 4'd1) ? DEAD : RAMP;
          end else begin
            state_nx_s = RAMP;
          end
        end else if (sb_s) begin
          level_nx_s = step_lvl_s;
          if (step_lvl_s == target_s) begin
            state_nx_s = (target_s == 4'd0) ? IDLE : RUN;
          end else begin
            state_nx_s = RAMP;
          end
        end else begin
          state_nx_s = RAMP;
        end
      end
      RUN: begin
        if (differ_s || (target_s != level_r)) begin
          state_nx_s = RAMP;
        end else begin
          state_nx_s = RUN;
        end
      end
      DEAD: begin
        if (dead_done_s) begin
          active_nx_s = mode_q_r;
          state_nx_s  = (target_s != 4'd0) ? RAMP : IDLE;
        end else begin
          state_nx_s = DEAD;
        end
      end
      default: begin
        state_nx_s = IDLE;
        level_nx_s = 4'd0;
      end
    endcase
  end

  // State, level, dead-band counter and registered drive outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      level_r  <= 4'd0;
      active_r <= 1'b0;
      dead_r   <= '0;
      heat_r   <= 1'b0;
      cool_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      level_r  <= level_nx_s;
      active_r <= active_nx_s;
      dead_r   <= ((state_r == DEAD) && !dead_done_s) ? dead_r + DW'(1) : '0;
      heat_r   <= pwm_raw_s & active_r & (state_r != DEAD);
      cool_r   <= pwm_raw_s & ~active_r & (state_r != DEAD);
      busy_r   <= (state_nx_s == RAMP) || (state_nx_s == DEAD);
    end
  end

  assign bus.heat_pwm        = heat_r;
  assign bus.cool_pwm        = cool_r;
  assign bus.chs_level       = level_r;
  assign bus.chs_active_mode = active_r;
  assign bus.chs_busy        = busy_r;
endmodule

// File: tb/tb_chs_power_driver.sv
// Bench for chs_power_driver: directed scenarios plus random segments, every clock
// compared against a timeline model driven by the absolute edge count since reset.
module tb_chs_power_driver;
  localparam int P = 4;
  localparam int R = 2;
  localparam int D = 16;
  localparam int PERIOD = 8 * P;
  localparam int STEP   = PERIOD * R;
  localparam int PH_IDLE = 0, PH_RAMP = 1, PH_RUN = 2, PH_DEAD = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  chs_power_driver_if bus_if();

  chs_power_driver #(.PRESCALE(P), .RAMP_PERIODS(R), .DEAD_CYCLES(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: edge count since reset, sampled inputs, applied level/mode, phase
  int m_k, m_pq, m_mq, m_lvl, m_act, m_ph, m_dstart;
  int m_heat, m_cool;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_pq = 0; m_mq = 0; m_lvl = 0; m_act = 0;
    m_ph = PH_IDLE; m_dstart = 0; m_heat = 0; m_cool = 0;
  endtask

  task automatic model_edge();
    int tgt, slot;
    bit sb, on;
    tgt  = (m_pq > 8) ? 8 : m_pq;
    sb   = ((m_k % STEP) == STEP - 1);
    slot = (m_k / P) % 8;
    on   = (slot < m_lvl) && (m_ph != PH_DEAD);
    m_heat = (on && m_act == 1) ? 1 : 0;
    m_cool = (on && m_act == 0) ? 1 : 0;
    if (m_ph == PH_IDLE) begin
      if (tgt > 0) begin
        if (m_mq == m_act) m_ph = PH_RAMP;
        else begin m_ph = PH_DEAD; m_dstart = m_k; end
      end
    end else if (m_ph == PH_RAMP) begin
      if (m_mq != m_act) begin
        if (m_lvl == 0) begin m_ph = PH_DEAD; m_dstart = m_k; end
        else if (sb) begin
          m_lvl--;
          if (m_lvl == 0) begin m_ph = PH_DEAD; m_dstart = m_k; end
        end
      end else if (sb) begin
        if (tgt > m_lvl) m_lvl++;
        else if (tgt < m_lvl) m_lvl--;
        if (m_lvl == tgt) m_ph = (tgt == 0) ? PH_IDLE : PH_RUN;
      end
    end else if (m_ph == PH_RUN) begin
      if (tgt != m_lvl || m_mq != m_act) m_ph = PH_RAMP;
    end else begin
      if (m_k == m_dstart + D) begin
        m_act = m_mq;
        m_ph  = (tgt > 0) ? PH_RAMP : PH_IDLE;
      end
    end
    m_pq = int'(bus_if.chs_power);
    m_mq = int'(bus_if.chs_mode);
    m_k++;
  endtask

  task automatic check_all();
    chk("heat_pwm", bus_if.heat_pwm, m_heat[7:0]);
    chk("cool_pwm", bus_if.cool_pwm, m_cool[7:0]);
    chk("chs_level", bus_if.chs_level, m_lvl[7:0]);
    chk("active_mode", bus_if.chs_active_mode, m_act[7:0]);
    chk("chs_busy", bus_if.chs_busy, (m_ph == PH_RAMP || m_ph == PH_DEAD) ? 8'd1 : 8'd0);
    chk("no_overlap", bus_if.heat_pwm & bus_if.cool_pwm, 8'd0);
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst) model_reset();
    else model_edge();
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_heat"}, bus_if.heat_pwm, 8'd0);
    chk({tag, "_cool"}, bus_if.cool_pwm, 8'd0);
    chk({tag, "_level"}, bus_if.chs_level, 8'd0);
    chk({tag, "_mode"}, bus_if.chs_active_mode, 8'd0);
    chk({tag, "_busy"}, bus_if.chs_busy, 8'd0);
  endtask

  // Assert reset between edges, confirm outputs clear before the next edge, hold, release.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_zero(tag);
    model_reset();
    ticks(3);
    rst = 1'b0;
  endtask

  task automatic count_window(output int h, output int c);
    h = 0; c = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      h += int'(bus_if.heat_pwm);
      c += int'(bus_if.cool_pwm);
    end
  endtask

  initial begin
    int h, c;
    model_reset();
    // T1: reset with arbitrary inputs
    bus_if.chs_power = 4'($urandom_range(0, 15));
    bus_if.chs_mode  = 1'($urandom_range(0, 1));
    pulse_reset("t1_async");

    // T2: cool ramp to 4
    bus_if.chs_power = 4'd4;
    bus_if.chs_mode  = 1'b0;
    ticks(STEP); chk("t2_step1", bus_if.chs_level, 8'd1);
    ticks(STEP); chk("t2_step2", bus_if.chs_level, 8'd2);
    ticks(STEP); chk("t2_step3", bus_if.chs_level, 8'd3);
    ticks(STEP); chk("t2_step4", bus_if.chs_level, 8'd4);
    ticks(4);
    count_window(h, c);
    chk("t2_cool_duty", 8'(c), 8'd16);
    chk("t2_heat_duty", 8'(h), 8'd0);
    chk("t2_busy", bus_if.chs_busy, 8'd0);

    // T3: full power, then out-of-range request clamps
    bus_if.chs_power = 4'd8;
    ticks(5 * STEP);
    chk("t3_level8", bus_if.chs_level, 8'd8);
    count_window(h, c);
    chk("t3_cool_full", 8'(c), 8'd32);
    bus_if.chs_power = 4'd13;
    ticks(STEP);
    chk("t3_clamp_level", bus_if.chs_level, 8'd8);
    count_window(h, c);
    chk("t3_clamp_cool", 8'(c), 8'd32);

    // T4: reversal from cool level 4 to heat
    bus_if.chs_power = 4'd4;
    ticks(5 * STEP);
    chk("t4_pre_level", bus_if.chs_level, 8'd4);
    bus_if.chs_mode = 1'b1;
    ticks(10 * STEP);
    chk("t4_level", bus_if.chs_level, 8'd4);
    chk("t4_mode", bus_if.chs_active_mode, 8'd1);
    count_window(h, c);
    chk("t4_heat_duty", 8'(h), 8'd16);
    chk("t4_cool_duty", 8'(c), 8'd0);

    // T5: short-lived target change inside one step window
    bus_if.chs_power = 4'd3;
    ticks(2 * STEP);
    chk("t5_pre_level", bus_if.chs_level, 8'd3);
    while ((m_k % STEP) != 0) tick();
    bus_if.chs_power = 4'd5;
    ticks(10);
    bus_if.chs_power = 4'd3;
    ticks(20);
    ticks(STEP);
    chk("t5_level_held", bus_if.chs_level, 8'd3);

    // T6: reset in the middle of a ramp
    pulse_reset("t6_pre");
    bus_if.chs_power = 4'd5;
    bus_if.chs_mode  = 1'b0;
    ticks(2 * STEP + 32);
    chk("t6_mid_level", bus_if.chs_level, 8'd2);
    pulse_reset("t6_async");
    ticks(STEP);
    chk("t6_restart", bus_if.chs_level, 8'd1);

    // Random segments
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 9) == 0) pulse_reset("rnd_rst");
      bus_if.chs_power = 4'($urandom_range(0, 15));
      bus_if.chs_mode  = 1'($urandom_range(0, 1));
      ticks($urandom_range(1, 200));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
